// File: rtl/multi_hexdriver.sv
// multi_hexdriver
//   Multi-digit 7-segment driver. A load strobe captures a binary value and a
//   radix select; hex mode maps nibbles straight to digits, decimal mode runs a
//   sequential double-dabble conversion (one bit per cycle) first. All display
//   outputs are registered and active-low (segment order gfe_dcba).
//
//   Optional feature (compile-time macro HEX_LZ_BLANK_EN):
//     defined   -> leading zero digits are blanked, display 0 is never blanked
//     undefined -> every display shows its digit, leading zeros included
//
// Parameters
//   WIDTH    bit width of the input value (>= 1)
//   DIGITS   number of 7-segment displays driven (>= 1)
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   load      1-cycle strobe, accepted only while busy == 0
//   value     unsigned value to display
//   hex_mode  1 = hexadecimal, 0 = decimal
//   busy      high while a request is in progress
//   done      1-cycle pulse once HEX has been updated
//   HEX       display d on HEX[7*d+6:7*d], d = 0 least significant

module multi_hexdriver #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  input  logic                  hex_mode,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   HEX
);

  // BCD digits needed to hold 2^WIDTH-1 (conservative bound).
  localparam int unsigned ND = (WIDTH + 2) / 3;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  // Nibble counts padded so every display index is a legal select.
  localparam int unsigned NP = (ND > DIGITS) ? ND : DIGITS;
  localparam int unsigned NH = ((WIDTH + 3) / 4 > DIGITS) ? (WIDTH + 3) / 4 : DIGITS;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StConv = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [6:0] SegZero  = 7'b100_0000;
  localparam logic [6:0] SegDash  = 7'b011_1111;
  localparam logic [6:0] SegBlank = 7'b111_1111;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [4*ND-1:0]     bcd_q, bcd_d;
  logic                hexm_q, hexm_d;
  logic                done_q, done_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;

  // Active-low segment pattern for one nibble.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b100_0000;
      4'h1:    s = 7'b111_1001;
      4'h2:    s = 7'b010_0100;
      4'h3:    s = 7'b011_0000;
      4'h4:    s = 7'b001_1001;
      4'h5:    s = 7'b001_0010;
      4'h6:    s = 7'b000_0010;
      4'h7:    s = 7'b111_1000;
      4'h8:    s = 7'b000_0000;
      4'h9:    s = 7'b001_1000;
      4'hA:    s = 7'b000_1000;
      4'hB:    s = 7'b000_0011;
      4'hC:    s = 7'b100_0110;
      4'hD:    s = 7'b010_0001;
      4'hE:    s = 7'b000_0110;
      default: s = 7'b000_1110;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Double-dabble step: add 3 to every BCD nibble >= 5, then shift in value MSB.
  // ---------------------------------------------------------------------------
  logic [4*ND-1:0]  bcd_adj;
  logic [4*ND-1:0]  bcd_step;
  logic [WIDTH-1:0] sh_step;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_step = (bcd_adj << 1) | {{(4*ND-1){1'b0}}, sh_q[WIDTH-1]};
    sh_step  = sh_q << 1;
  end

  // ---------------------------------------------------------------------------
  // Display image computed from the finished result; registered in StDone.
  // ---------------------------------------------------------------------------
  logic [4*NP-1:0]     bcd_pad;
  logic [4*NH-1:0]     hex_pad;
  logic                ovf;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] disp;
`ifdef HEX_LZ_BLANK_EN
  logic                lead;
`endif

  always_comb begin
    bcd_pad = '0;
    bcd_pad[4*ND-1:0] = bcd_q;
    // In hex mode the shift register still holds the captured value untouched.
    hex_pad = '0;
    hex_pad[WIDTH-1:0] = sh_q;

    // Any set bit above the displayable range means overflow.
    ovf = 1'b0;
    if (hexm_q) begin
      for (int unsigned i = 0; i < 4*NH; i++) begin
        if (i >= 4*DIGITS) ovf = ovf | hex_pad[i];
      end
    end else begin
      for (int unsigned i = 0; i < 4*NP; i++) begin
        if (i >= 4*DIGITS) ovf = ovf | bcd_pad[i];
      end
    end

    for (int unsigned d = 0; d < DIGITS; d++) begin
      nib[d] = hexm_q ? hex_pad[4*d +: 4] : bcd_pad[4*d +: 4];
    end

    blank = '0;
`ifdef HEX_LZ_BLANK_EN
    // Scan from the most significant display down; stop at the first nonzero.
    lead = 1'b1;
    for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
      if (lead && (nib[d] == 4'h0)) begin
        blank[d] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
`endif

    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (ovf) begin
        disp[7*d +: 7] = SegDash;
      end else if (blank[d]) begin
        disp[7*d +: 7] = SegBlank;
      end else begin
        disp[7*d +: 7] = seg7(nib[d]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: IDLE -> (CONV x WIDTH) -> DONE -> IDLE, hex skips CONV.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    hexm_d  = hexm_q;
    done_d  = 1'b0;
    hex_d   = hex_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          sh_d    = value;
          hexm_d  = hex_mode;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = hex_mode ? StDone : StConv;
        end
      end
      StConv: begin
        bcd_d = bcd_step;
        sh_d  = sh_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = StDone;
      end
      StDone: begin
        hex_d   = disp;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      hexm_q  <= 1'b0;
      done_q  <= 1'b0;
      hex_q   <= {DIGITS{SegZero}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      hexm_q  <= hexm_d;
      done_q  <= done_d;
      hex_q   <= hex_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign HEX  = hex_q;

endmodule

// File: tb/tb_multi_hexdriver.sv
module tb_multi_hexdriver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        hex_mode;
  logic        busy;
  logic        done;
  logic [27:0] HEX;

  multi_hexdriver #(.WIDTH(16), .DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .value    (value),
    .hex_mode (hex_mode),
    .busy     (busy),
    .done     (done),
    .HEX      (HEX)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef HEX_LZ_BLANK_EN
  localparam logic [6:0] Z = 7'h7F;
`else
  localparam logic [6:0] Z = 7'h40;
`endif

  typedef struct {
    logic [27:0] hex;
    int          due;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  exp_t e;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 want no pending request (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("hex", {4'h0, HEX}, {4'h0, e.hex});
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic wait_done(input string name, output int nb);
    bit seen;
    nb   = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      else if (busy === 1'b1) nb++;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done want done within 40 cycles", name);
    end
  endtask

  task automatic req(input string name, input logic [15:0] v, input logic hm,
                     input logic [27:0] exp);
    int nb;
    @(posedge clk); #1;
    sb.push_back('{exp, cyc + (hm ? 2 : 18)});
    value    = v;
    hex_mode = hm;
    load     = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    wait_done(name, nb);
    check({name, "_busy"}, nb, hm ? 1 : 17);
  endtask

  initial begin
    int nb;
    reset = 1'b1; load = 1'b0; value = '0; hex_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_hex", {4'h0, HEX}, {4'h0, {4{7'h40}}});
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    req("hex_beef", 16'hBEEF, 1'b1, {7'h03, 7'h06, 7'h06, 7'h0E});
    req("dec_1234", 16'd1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19});

    // Reset sampled at CONV step 5 discards the conversion.
    @(posedge clk); #1;
    value = 16'd9999; hex_mode = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_hex", {4'h0, HEX}, {4'h0, {4{7'h40}}});
    check("midrst_done", done, 1'b0);
    repeat (25) @(posedge clk);

    req("dec_9999", 16'd9999, 1'b0, {4{7'h18}});
    req("dec_10000", 16'd10000, 1'b0, {4{7'h3F}});
    req("dec_7", 16'd7, 1'b0, {Z, Z, Z, 7'h78});
    req("dec_65535", 16'd65535, 1'b0, {4{7'h3F}});
    req("dec_42", 16'd42, 1'b0, {Z, Z, 7'h19, 7'h24});
    req("dec_0", 16'd0, 1'b0, {Z, Z, Z, 7'h40});
    req("hex_a5", 16'h00A5, 1'b1, {Z, Z, 7'h08, 7'h12});
    req("hex_ffff", 16'hFFFF, 1'b1, {4{7'h0E}});
    req("hex_0", 16'h0000, 1'b1, {Z, Z, Z, 7'h40});

    // Load during busy cycle 3 must be ignored.
    @(posedge clk); #1;
    sb.push_back('{{Z, Z, 7'h12, 7'h12}, cyc + 18});
    value = 16'd55; hex_mode = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1 value = 16'd99; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("ign_busy", busy, 1'b1);
    wait_done("dec_55", nb);
    repeat (25) @(posedge clk);

    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
